// File: rtl/text_video_pkg.sv
// Shared constants for the text-mode video path: grid defaults, sweep fill
// values, control codes and the text_writer state encoding.
package text_video_pkg;
    localparam int         TV_COLS         = 80;
    localparam int         TV_ROWS         = 30;
    localparam int         TV_XW           = 7;
    localparam int         TV_YW           = 5;
    localparam logic [7:0] TV_BLANK_CHAR   = 8'h20;
    localparam logic [7:0] TV_DEFAULT_ATTR = 8'h07;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_CLRALL = 2'd0,
        ST_IDLE   = 2'd1,
        ST_CLRROW = 2'd2
    } tw_state_e;
endpackage

// File: rtl/text_cursor.sv
// Text cursor registers: advance, newline, backspace, carriage return and
// home, wrapping at the last column / last row.
module text_cursor
    import text_video_pkg::*;
#(
    parameter int COLS = TV_COLS,
    parameter int ROWS = TV_ROWS,
    parameter int XW   = TV_XW,
    parameter int YW   = TV_YW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv_i,
    input  logic          lf_i,
    input  logic          bs_i,
    input  logic          cr_i,
    input  logic          home_i,
    output logic          eol_o,
    output logic [XW-1:0] cur_x_o,
    output logic [YW-1:0] cur_y_o
);
    localparam int            LAST_X_I = COLS - 1;
    localparam int            LAST_Y_I = ROWS - 1;
    localparam int            ONE_I    = 1;
    localparam logic [XW-1:0] LAST_X   = LAST_X_I[XW-1:0];
    localparam logic [YW-1:0] LAST_Y   = LAST_Y_I[YW-1:0];
    localparam logic [XW-1:0] ONE_X    = ONE_I[XW-1:0];
    localparam logic [YW-1:0] ONE_Y    = ONE_I[YW-1:0];

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          nl;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        // A printable in the last column wraps and behaves like LF.
        nl  = lf_i || (adv_i && (x_q == LAST_X));
        if (home_i) begin
            x_d = '0;
            y_d = '0;
        end else begin
            if (cr_i)
                x_d = '0;
            else if (bs_i && (x_q != '0))
                x_d = x_q - ONE_X;
            else if (adv_i)
                x_d = (x_q == LAST_X) ? '0 : x_q + ONE_X;
            if (nl)
                y_d = (y_q == LAST_Y) ? '0 : y_q + ONE_Y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign eol_o   = (x_q == LAST_X);
    assign cur_x_o = x_q;
    assign cur_y_o = y_q;
endmodule

// File: rtl/text_writer.sv
// Byte stream to character-memory writer with cursor, row-clear and full-clear
// sweeps. Define TEXT_WRITER_CTRL_EN to interpret BS/LF/FF/CR control codes.
module text_writer
    import text_video_pkg::*;
#(
    parameter int         COLS         = TV_COLS,
    parameter int         ROWS         = TV_ROWS,
    parameter int         XW           = TV_XW,
    parameter int         YW           = TV_YW,
    parameter logic [7:0] BLANK_CHAR   = TV_BLANK_CHAR,
    parameter logic [7:0] DEFAULT_ATTR = TV_DEFAULT_ATTR
) (
    input  logic          CLK,
    input  logic          _RST,
    input  logic [7:0]    CHAR_IN,
    input  logic [7:0]    ATTR_IN,
    input  logic          VALID,
    output logic          READY,
    output logic          WE,
    output logic [XW-1:0] WADDR_X,
    output logic [YW-1:0] WADDR_Y,
    output logic [7:0]    WCHAR,
    output logic [7:0]    WATTR,
    output logic [XW-1:0] CUR_X,
    output logic [YW-1:0] CUR_Y
);
    // Sweep counters carry one extra bit so the "one past last" value is
    // representable even when COLS/ROWS equal 2^XW / 2^YW.
    localparam int          LAST_X_I = COLS - 1;
    localparam int          ONE_I    = 1;
    localparam logic [XW:0] SW_LAST_X = LAST_X_I[XW:0];
    localparam logic [XW:0] SW_END_X  = COLS[XW:0];
    localparam logic [YW:0] SW_END_Y  = ROWS[YW:0];
    localparam logic [XW:0] SW_ONE_X  = ONE_I[XW:0];
    localparam logic [YW:0] SW_ONE_Y  = ONE_I[YW:0];

    tw_state_e     state_q, state_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic [XW-1:0] waddr_x_q, waddr_x_d;
    logic [YW-1:0] waddr_y_q, waddr_y_d;
    logic [7:0]    wchar_q, wchar_d;
    logic [7:0]    wattr_q, wattr_d;
    logic [XW:0]   cnt_x_q, cnt_x_d;
    logic [YW:0]   cnt_y_q, cnt_y_d;
    logic          print, lf, bs, cr, home, eol;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    text_cursor #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) u_cursor (
        .clk     (CLK),
        .rst_n   (_RST),
        .adv_i   (print),
        .lf_i    (lf),
        .bs_i    (bs),
        .cr_i    (cr),
        .home_i  (home),
        .eol_o   (eol),
        .cur_x_o (cur_x),
        .cur_y_o (cur_y)
    );

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        we_d      = 1'b0;
        waddr_x_d = waddr_x_q;
        waddr_y_d = waddr_y_q;
        wchar_d   = wchar_q;
        wattr_d   = wattr_q;
        cnt_x_d   = cnt_x_q;
        cnt_y_d   = cnt_y_q;
        print     = 1'b0;
        lf        = 1'b0;
        bs        = 1'b0;
        cr        = 1'b0;
        home      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (VALID && ready_q) begin
`ifdef TEXT_WRITER_CTRL_EN
                    case (CHAR_IN)
                        CC_CR:   cr    = 1'b1;
                        CC_BS:   bs    = 1'b1;
                        CC_LF:   lf    = 1'b1;
                        CC_FF:   home  = 1'b1;
                        default: print = 1'b1;
                    endcase
`else
                    print = 1'b1;
`endif
                    if (print) begin
                        we_d      = 1'b1;
                        waddr_x_d = cur_x;
                        waddr_y_d = cur_y;
                        wchar_d   = CHAR_IN;
                        wattr_d   = ATTR_IN;
                    end
                    if (lf || (print && eol)) begin
                        ready_d = 1'b0;
                        state_d = ST_CLRROW;
                        cnt_x_d = '0;
                    end
                    if (home) begin
                        ready_d = 1'b0;
                        state_d = ST_CLRALL;
                        cnt_x_d = '0;
                        cnt_y_d = '0;
                    end
                end
            end
            // The cursor already points at the new row during the row clear.
            ST_CLRROW: begin
                if (cnt_x_q == SW_END_X) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    we_d      = 1'b1;
                    waddr_x_d = cnt_x_q[XW-1:0];
                    waddr_y_d = cur_y;
                    wchar_d   = BLANK_CHAR;
                    wattr_d   = DEFAULT_ATTR;
                    cnt_x_d   = cnt_x_q + SW_ONE_X;
                end
            end
            ST_CLRALL: begin
                if (cnt_y_q == SW_END_Y) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    we_d      = 1'b1;
                    waddr_x_d = cnt_x_q[XW-1:0];
                    waddr_y_d = cnt_y_q[YW-1:0];
                    wchar_d   = BLANK_CHAR;
                    wattr_d   = DEFAULT_ATTR;
                    if (cnt_x_q == SW_LAST_X) begin
                        cnt_x_d = '0;
                        cnt_y_d = cnt_y_q + SW_ONE_Y;
                    end else begin
                        cnt_x_d = cnt_x_q + SW_ONE_X;
                    end
                end
            end
            default: state_d = ST_CLRALL;
        endcase
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q   <= ST_CLRALL;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_x_q <= '0;
            waddr_y_q <= '0;
            wchar_q   <= BLANK_CHAR;
            wattr_q   <= DEFAULT_ATTR;
            cnt_x_q   <= '0;
            cnt_y_q   <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            waddr_x_q <= waddr_x_d;
            waddr_y_q <= waddr_y_d;
            wchar_q   <= wchar_d;
            wattr_q   <= wattr_d;
            cnt_x_q   <= cnt_x_d;
            cnt_y_q   <= cnt_y_d;
        end
    end

    assign READY   = ready_q;
    assign WE      = we_q;
    assign WADDR_X = waddr_x_q;
    assign WADDR_Y = waddr_y_q;
    assign WCHAR   = wchar_q;
    assign WATTR   = wattr_q;
    assign CUR_X   = cur_x;
    assign CUR_Y   = cur_y;
endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected cell writes are queued as bytes
// are driven and checked against every WE cycle by a monitor.
module tb_text_writer;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    typedef struct packed {
        logic [6:0] x;
        logic [4:0] y;
        logic [7:0] c;
        logic [7:0] a;
    } cell_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic [7:0] attr_in = 8'h00;
    logic       ready, we;
    logic [6:0] waddr_x, cur_x;
    logic [4:0] waddr_y, cur_y;
    logic [7:0] wchar, wattr;

    cell_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    wcount = 0;
    int    mx = 0;
    int    my = 0;

    always #5 clk = ~clk;

    text_writer dut (
        .CLK     (clk),
        ._RST    (rst_n),
        .CHAR_IN (char_in),
        .ATTR_IN (attr_in),
        .VALID   (valid),
        .READY   (ready),
        .WE      (we),
        .WADDR_X (waddr_x),
        .WADDR_Y (waddr_y),
        .WCHAR   (wchar),
        .WATTR   (wattr),
        .CUR_X   (cur_x),
        .CUR_Y   (cur_y)
    );

    // Write monitor: every registered write must match the head of the queue.
    always @(negedge clk) begin
        cell_t e;
        if (rst_n && we) begin
            wcount++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected got (%0d,%0d,%h,%h) want none", waddr_x, waddr_y, wchar, wattr);
            end else begin
                e = exp_q.pop_front();
                if ({waddr_x, waddr_y, wchar, wattr} !== e) begin
                    bad++;
                    $display("FAIL write got (%0d,%0d,%h,%h) want (%0d,%0d,%h,%h)",
                             waddr_x, waddr_y, wchar, wattr, e.x, e.y, e.c, e.a);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cell(input int x, input int y, input logic [7:0] c, input logic [7:0] a);
        cell_t e;
        e.x = x[6:0];
        e.y = y[4:0];
        e.c = c;
        e.a = a;
        exp_q.push_back(e);
    endtask

    task automatic push_row(input int y);
        for (int c = 0; c < COLS; c++) push_cell(c, y, 8'h20, 8'h07);
    endtask

    task automatic push_all();
        for (int r = 0; r < ROWS; r++) push_row(r);
    endtask

    task automatic model_newline();
        my = (my == ROWS - 1) ? 0 : my + 1;
        push_row(my);
    endtask

    task automatic model_byte(input logic [7:0] c, input logic [7:0] a);
`ifdef TEXT_WRITER_CTRL_EN
        if (c == 8'h0D) begin
            mx = 0;
            return;
        end
        if (c == 8'h08) begin
            if (mx > 0) mx--;
            return;
        end
        if (c == 8'h0A) begin
            model_newline();
            return;
        end
        if (c == 8'h0C) begin
            mx = 0;
            my = 0;
            push_all();
            return;
        end
`endif
        push_cell(mx, my, c, a);
        if (mx == COLS - 1) begin
            mx = 0;
            model_newline();
        end else begin
            mx++;
        end
    endtask

    // Holds VALID until READY is seen, then returns just after the accept edge.
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n;
        n = 0;
        char_in = c;
        attr_in = a;
        valid = 1'b1;
        while (!ready && n < 3000) begin
            step();
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout ready=%b want 1", ready);
            valid = 1'b0;
            return;
        end
        model_byte(c, a);
        step();
        valid = 1'b0;
    endtask

    task automatic reset_sweep(output int cyc);
        rst_n = 1'b0;
        valid = 1'b0;
        exp_q.delete();
        step();
        step();
        push_all();
        mx = 0;
        my = 0;
        rst_n = 1'b1;
        cyc = 0;
        while (!ready && cyc < 5000) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc, w0;
        rst_n = 1'b0;
        step();
        total++;
        if ({ready, we, waddr_x, waddr_y, wchar, wattr, cur_x, cur_y} !==
            {1'b0, 1'b0, 7'd0, 5'd0, 8'h20, 8'h07, 7'd0, 5'd0}) begin
            bad++;
            $display("FAIL reset_values got r=%b we=%b (%0d,%0d) %h %h cur=(%0d,%0d) want 0 0 (0,0) 20 07 (0,0)",
                     ready, we, waddr_x, waddr_y, wchar, wattr, cur_x, cur_y);
        end
        w0 = wcount;
        reset_sweep(cyc);
        total++;
        if (cyc !== 2401) begin bad++; $display("FAIL clrall_cycles got %0d want 2401", cyc); end
        total++;
        if (wcount - w0 !== 2400) begin bad++; $display("FAIL clrall_writes got %0d want 2400", wcount - w0); end
        total++;
        if (we !== 1'b0) begin bad++; $display("FAIL clrall_we_at_ready got %b want 0", we); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL clrall_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wcount;
        send(8'h41, 8'h1E);
        total++;
        if (wcount - w0 !== 1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got writes=%0d ready=%b want 1 1", wcount - w0, ready);
        end
        send(8'h42, 8'h1E);
        total++;
        if (wcount - w0 !== 2) begin bad++; $display("FAIL b2b_writes got %0d want 2", wcount - w0); end
        total++;
        if ({cur_x, cur_y} !== {7'd2, 5'd0}) begin bad++; $display("FAIL b2b_cursor got (%0d,%0d) want (2,0)", cur_x, cur_y); end
    endtask

    task automatic test_row_wrap();
        int cyc, n;
        reset_sweep(cyc);
        total++;
        if (cyc !== 2401) begin bad++; $display("FAIL wrap_sweep got %0d want 2401", cyc); end
        for (int i = 0; i < COLS; i++) send(8'h41 + 8'(i % 26), 8'(i));
        total++;
        if ({cur_x, cur_y} !== {7'd0, 5'd1}) begin bad++; $display("FAIL wrap_cursor got (%0d,%0d) want (0,1)", cur_x, cur_y); end
        n = 0;
        while (!ready && n < 200) begin
            n++;
            step();
        end
        total++;
        if (n !== 81) begin bad++; $display("FAIL wrap_ready_low got %0d want 81", n); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL wrap_left got %0d want 0", exp_q.size()); end
    endtask

`ifdef TEXT_WRITER_CTRL_EN
    task automatic test_ctrl_codes();
        int cyc, n, w0;
        reset_sweep(cyc);
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send(8'h61, 8'h0F);
        total++;
        if ({cur_x, cur_y} !== {7'd5, 5'd29}) begin bad++; $display("FAIL ctrl_pos got (%0d,%0d) want (5,29)", cur_x, cur_y); end
        send(8'h0A, 8'h00);
        total++;
        if ({cur_x, cur_y, ready} !== {7'd5, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL lf_wrap got (%0d,%0d) r=%b want (5,0) r=0", cur_x, cur_y, ready);
        end
        n = 0;
        while (!ready && n < 200) begin
            n++;
            step();
        end
        total++;
        if (n !== 81 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL lf_clear got low=%0d left=%0d want 81 0", n, exp_q.size());
        end
        w0 = wcount;
        send(8'h0D, 8'h00);
        total++;
        if (cur_x !== 7'd0) begin bad++; $display("FAIL cr got %0d want 0", cur_x); end
        send(8'h08, 8'h00);
        step();
        step();
        total++;
        if ({cur_x, cur_y} !== {7'd0, 5'd0} || wcount !== w0) begin
            bad++;
            $display("FAIL bs_at_zero got (%0d,%0d) writes=%0d want (0,0) 0", cur_x, cur_y, wcount - w0);
        end
        send(8'h7A, 8'h02);
        send(8'h7A, 8'h02);
        send(8'h08, 8'h00);
        total++;
        if (cur_x !== 7'd1) begin bad++; $display("FAIL bs_back got %0d want 1", cur_x); end
    endtask

    task automatic test_form_feed();
        int n;
        send(8'h71, 8'h03);
        send(8'h72, 8'h03);
        send(8'h0C, 8'h00);
        total++;
        if ({cur_x, cur_y, ready} !== {7'd0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL ff_home got (%0d,%0d) r=%b want (0,0) r=0", cur_x, cur_y, ready);
        end
        n = 0;
        while (!ready && n < 3000) begin
            n++;
            step();
        end
        total++;
        if (n !== 2401) begin bad++; $display("FAIL ff_sweep got %0d want 2401", n); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL ff_left got %0d want 0", exp_q.size()); end
    endtask
`else
    task automatic test_literal();
        int cyc, w0;
        reset_sweep(cyc);
        for (int i = 0; i < 3 * COLS + 3; i++) send(8'h30, 8'h01);
        total++;
        if ({cur_x, cur_y} !== {7'd3, 5'd3}) begin bad++; $display("FAIL lit_pos got (%0d,%0d) want (3,3)", cur_x, cur_y); end
        w0 = wcount;
        send(8'h0A, 8'h5A);
        total++;
        if ({cur_x, cur_y} !== {7'd4, 5'd3}) begin bad++; $display("FAIL lit_cursor got (%0d,%0d) want (4,3)", cur_x, cur_y); end
        step();
        step();
        step();
        total++;
        if (wcount - w0 !== 1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL lit_no_clear got writes=%0d ready=%b want 1 1", wcount - w0, ready);
        end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL lit_left got %0d want 0", exp_q.size()); end
    endtask
`endif

    task automatic test_reset_abort();
        int cyc, w0, n;
        rst_n = 1'b0;
        exp_q.delete();
        step();
        push_all();
        w0 = wcount;
        rst_n = 1'b1;
        n = 0;
        while (wcount - w0 < 1000 && n < 3000) begin
            step();
            n++;
        end
        total++;
        if (wcount - w0 !== 1000) begin bad++; $display("FAIL abort_reach got %0d want 1000", wcount - w0); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, we, waddr_x, waddr_y, wchar, wattr, cur_x, cur_y} !==
            {1'b0, 1'b0, 7'd0, 5'd0, 8'h20, 8'h07, 7'd0, 5'd0}) begin
            bad++;
            $display("FAIL abort_values got r=%b we=%b (%0d,%0d) %h %h want 0 0 (0,0) 20 07",
                     ready, we, waddr_x, waddr_y, wchar, wattr);
        end
        reset_sweep(cyc);
        total++;
        if (cyc !== 2401) begin bad++; $display("FAIL abort_restart got %0d want 2401", cyc); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL abort_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_row_wrap();
`ifdef TEXT_WRITER_CTRL_EN
        test_ctrl_codes();
        test_form_feed();
`else
        test_literal();
`endif
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/text_writer.md
# text_writer

Upstream feeder for the character memory in the text-mode video path. Accepts a byte stream (character plus attribute) over a VALID/READY handshake and turns it into single-cell writes on the character memory write port. Maintains a text cursor on the 80x30 grid (640x480 at 8x16 glyphs), interprets control codes, and runs hardware clear sweeps for row wrap, form feed and power-up.

## Interface
- COLS, 80: text columns; must be ≤ 2^XW.
- ROWS, 30: text rows; must be ≤ 2^YW.
- XW, 7: column address width.
- YW, 5: row address width.
- BLANK_CHAR, 8'h20: character code written by clear sweeps.
- DEFAULT_ATTR, 8'h07: attribute written by clear sweeps.

- CLK  input  1  system/pixel clock, all logic on rising edge.
- _RST  input  1  asynchronous, active-low reset.
- CHAR_IN  input  8  incoming byte.
- ATTR_IN  input  8  attribute for CHAR_IN.
- VALID  input  1  CHAR_IN/ATTR_IN valid.
- READY  output  1  byte accepted on the rising edge where VALID && READY.
- WE  output  1  char memory write strobe, one cell per cycle.
- WADDR_X  output  XW  write column.
- WADDR_Y  output  YW  write row.
- WCHAR  output  8  write character.
- WATTR  output  8  write attribute.
- CUR_X  output  XW  cursor column.
- CUR_Y  output  YW  cursor row.

## Operation
- States: CLRALL, IDLE, CLRROW. Reset enters CLRALL with sweep counters at (0,0).
- IDLE: READY=1. On accept, act on CHAR_IN:
  - 8'h0D CR: CUR_X←0; no write.
  - 8'h0A LF: newline; CUR_X unchanged.
  - 8'h08 BS: CUR_X←CUR_X−1 if CUR_X>0, else unchanged; no write.
  - 8'h0C FF: cursor←(0,0), go CLRALL.
  - Any other byte (printable): write (CUR_X,CUR_Y,CHAR_IN,ATTR_IN). If CUR_X==COLS−1, CUR_X←0 and newline; else CUR_X+1.
- Newline: CUR_Y←(CUR_Y==ROWS−1)?0:CUR_Y+1. Go CLRROW for the new CUR_Y.
- CLRROW: writes (c,CUR_Y,BLANK_CHAR,DEFAULT_ATTR) for c=0..COLS−1, one per cycle, then IDLE.
- CLRALL: writes every cell row-major, (0,0)…(COLS−1,ROWS−1), COLS*ROWS cycles, then IDLE.
- No scrolling. The display wraps to row 0, and the destination row is cleared before new text lands there.
- Outputs while not writing: WE=0; WADDR/WCHAR/WATTR hold their last values.

## Timing
- All outputs are registered.
- Reset values: READY=0, WE=0, WADDR_X=0, WADDR_Y=0, WCHAR=BLANK_CHAR, WATTR=DEFAULT_ATTR, CUR_X=0, CUR_Y=0.
- Printable latency: the accept edge registers WE=1 with the pre-advance cursor address. The write is visible for exactly one cycle. CUR_X/CUR_Y show the advanced value from the same edge.
- Back-to-back printables that cause no newline: READY stays 1, one write per cycle, no bubbles.
- Newline-causing accept (LF, or a printable in the last column):
  - READY drops on the accept edge.
  - For a printable, that edge also registers its own write.
  - The next COLS edges register the row-clear writes.
  - The edge after the last clear write sets WE=0 and READY=1 together.
- Sweep cycle counts from entry edge to READY high:
  - Row clear: COLS+1 edges (81 at defaults).
  - CLRALL: COLS*ROWS+1 edges (2401 at defaults).
- After _RST deasserts, the first rising edge registers the write to (0,0).
- VALID is ignored while READY=0. The source must hold data until accepted.
- Reset mid-sweep or mid-stream: immediate abort to reset values. A full CLRALL restarts after deassertion.

## Configuration
- TEXT_WRITER_CTRL_EN defined: control codes 08/0A/0C/0D are interpreted as above.
- TEXT_WRITER_CTRL_EN undefined: every byte is printable and written literally. Only column overflow produces a newline and row clear. FF handling is removed; CLRALL is entered only from reset.

## Structure
- Shared package/header `text_video_pkg` holds:
  - COLS/ROWS defaults, BLANK_CHAR, DEFAULT_ATTR.
  - Control-code constants CC_BS, CC_LF, CC_FF, CC_CR.
  - FSM state encoding.
- One sub-module, `text_cursor`: cursor registers plus advance, newline, BS and home arithmetic, with wrap at COLS−1 / ROWS−1. The FSM and sweep counters stay in text_writer.

## Test plan
- Reset release → WE high for 2400 consecutive cycles, addresses (0,0)…(79,29) with 8'h20/8'h07. READY rises on the cycle WE falls.
- Send 'A','B' (attr 8'h1E) back-to-back at cursor (0,0) → writes (0,0,'A') then (1,0,'B') on consecutive cycles; CUR_X=2.
- 80 printables from (0,0) → 80th written at (79,0); CUR=(0,1); 80 clear writes on row 1; READY low for exactly 81 cycles after the 80th accept.
- At cursor (5,29) send LF → CUR=(5,0), row 0 cleared. Then CR → CUR_X=0; BS at X=0 → no change, no write.
- FF mid-line → cursor (0,0), full 2400-cell sweep. Assert _RST at sweep cell 1000 → outputs to reset values immediately; the sweep restarts at (0,0) after release.
- With TEXT_WRITER_CTRL_EN undefined, send 8'h0A at (3,3) → written literally at (3,3); CUR_X=4; no row clear.
